// File: rtl/img_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : img_pkg
//  Purpose  : Shared constants and types for the 3x3 image window controller.
//             PIXEL_W   - bits per pixel
//             WINDOW_W  - bits in one 3x3 window (9 pixels)
//             NUM_BANKS - rotating line banks
//             TAP_W     - one 3-tap row slice from a single bank
//  Revision : 1.0 - initial release
// ============================================================================
package img_pkg;

    localparam int PIXEL_W   = 8;
    localparam int WINDOW_W  = 72;
    localparam int NUM_BANKS = 4;
    localparam int TAP_W     = 3 * PIXEL_W;

    // Read-side sequencer states.
    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RD_LINE = 1'b1
    } rd_state_t;

    // Bank index; two bits so that increments wrap mod NUM_BANKS for free.
    typedef logic [1:0] bank_idx_t;

endpackage : img_pkg
`default_nettype wire

// File: rtl/line_bank.sv
`default_nettype none
// ============================================================================
//  Module   : line_bank
//  Purpose  : One image line of pixel storage (LUT RAM). Synchronous write
//             port, asynchronous 3-tap read of consecutive columns.
//  Ports    : i_clk      - clock, writes on rising edge
//             i_wr_en    - write enable
//             i_wr_addr  - write column
//             i_wr_data  - pixel to store
//             i_rd_addr  - first read column c
//             o_rd_taps  - {mem[c], mem[c+1], mem[c+2]} (columns mod width)
//  Revision : 1.0 - initial release
// ============================================================================
module line_bank
    import img_pkg::*;
#(
    parameter  int LINE_WIDTH = 512,
    localparam int ADDR_W     = $clog2(LINE_WIDTH)
) (
    input  logic                 i_clk,
    input  logic                 i_wr_en,
    input  logic [ADDR_W-1:0]    i_wr_addr,
    input  logic [PIXEL_W-1:0]   i_wr_data,
    input  logic [ADDR_W-1:0]    i_rd_addr,
    output logic [TAP_W-1:0]     o_rd_taps
);

    // Storage is intentionally not reset; stale contents are never exposed
    // as valid windows because reads only start after three fresh lines.
    logic [PIXEL_W-1:0] r_mem [LINE_WIDTH];

    logic [ADDR_W-1:0] w_addr1;
    logic [ADDR_W-1:0] w_addr2;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // LINE_WIDTH is a power of two, so the natural address overflow gives
    // the modulo wrap that makes the last two windows of a line pick up
    // columns 0 and 1.
    assign w_addr1   = i_rd_addr + ADDR_W'(1);
    assign w_addr2   = i_rd_addr + ADDR_W'(2);
    assign o_rd_taps = {r_mem[i_rd_addr], r_mem[w_addr1], r_mem[w_addr2]};

endmodule : line_bank
`default_nettype wire

// File: rtl/image_window_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : image_window_ctrl
//  Purpose  : Buffers a raster pixel stream across four rotating line banks
//             and, once three lines are held, emits one 3x3 window per cycle
//             for a full line, followed by a one-cycle interrupt.
//  Ports    : i_clk               - clock, rising edge
//             i_rstn              - synchronous active-low reset
//             i_pixel_data        - input pixel
//             i_pixel_data_valid  - input qualifier (no backpressure)
//             o_pixel_data        - {top[c..c+2], mid[c..c+2], bot[c..c+2]}
//             o_pixel_data_valid  - window qualifier
//             o_intr              - one-cycle pulse after each line read
//  Revision : 1.0 - initial release
// ============================================================================
module image_window_ctrl
    import img_pkg::*;
#(
    parameter int LINE_WIDTH = 512
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic [PIXEL_W-1:0]    i_pixel_data,
    input  logic                  i_pixel_data_valid,
    output logic [WINDOW_W-1:0]   o_pixel_data,
    output logic                  o_pixel_data_valid,
    output logic                  o_intr
);

    localparam int c_COL_W  = $clog2(LINE_WIDTH);
    localparam int c_FILL_W = $clog2(4 * LINE_WIDTH) + 1;

    localparam logic [c_COL_W-1:0]  c_LAST_COL  = c_COL_W'(LINE_WIDTH - 1);
    localparam logic [c_FILL_W-1:0] c_RD_THRESH = c_FILL_W'(3 * LINE_WIDTH);

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    logic [c_COL_W-1:0] r_wr_col;
    bank_idx_t          r_wr_bank;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_wr_col  <= '0;
            r_wr_bank <= '0;
        end else if (i_pixel_data_valid) begin
            r_wr_col <= r_wr_col + c_COL_W'(1);
            if (r_wr_col == c_LAST_COL) begin
                r_wr_bank <= r_wr_bank + 2'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Occupancy: pixels written but not yet consumed by a window
    // ------------------------------------------------------------------
    logic [c_FILL_W-1:0] r_fill;
    logic                r_rd_active;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_fill <= '0;
        end else begin
            case ({i_pixel_data_valid, r_rd_active})
                2'b10:   r_fill <= r_fill + c_FILL_W'(1);
                2'b01:   r_fill <= r_fill - c_FILL_W'(1);
                default: r_fill <= r_fill;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read sequencer
    // ------------------------------------------------------------------
    rd_state_t          r_state;
    rd_state_t          w_state_nxt;
    logic [c_COL_W-1:0] r_rd_col;
    logic [c_COL_W-1:0] w_rd_col_nxt;
    bank_idx_t          r_rd_bank;
    bank_idx_t          w_rd_bank_nxt;
    logic               w_rd_active_nxt;
    logic               r_intr;
    logic               w_intr_nxt;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state     <= IDLE;
            r_rd_col    <= '0;
            r_rd_bank   <= '0;
            r_rd_active <= 1'b0;
            r_intr      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rd_col    <= w_rd_col_nxt;
            r_rd_bank   <= w_rd_bank_nxt;
            r_rd_active <= w_rd_active_nxt;
            r_intr      <= w_intr_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_rd_col_nxt    = r_rd_col;
        w_rd_bank_nxt   = r_rd_bank;
        w_rd_active_nxt = r_rd_active;
        w_intr_nxt      = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_fill >= c_RD_THRESH) begin
                    w_state_nxt     = RD_LINE;
                    w_rd_active_nxt = 1'b1;
                end
            end
            RD_LINE: begin
                if (r_rd_col == c_LAST_COL) begin
                    // Line done: retire the top bank, the next burst reads
                    // one bank further round the ring.
                    w_rd_col_nxt    = '0;
                    w_rd_bank_nxt   = r_rd_bank + 2'd1;
                    w_rd_active_nxt = 1'b0;
                    w_intr_nxt      = 1'b1;
                    w_state_nxt     = IDLE;
                end else begin
                    w_rd_col_nxt = r_rd_col + c_COL_W'(1);
                end
            end
            default: begin
                w_state_nxt     = IDLE;
                w_rd_active_nxt = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Line banks and row mux
    // ------------------------------------------------------------------
    logic [TAP_W-1:0] w_taps [NUM_BANKS];

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        line_bank #(
            .LINE_WIDTH (LINE_WIDTH)
        ) u_line_bank (
            .i_clk      (i_clk),
            .i_wr_en    (i_pixel_data_valid && (r_wr_bank == bank_idx_t'(g))),
            .i_wr_addr  (r_wr_col),
            .i_wr_data  (i_pixel_data),
            .i_rd_addr  (r_rd_col),
            .o_rd_taps  (w_taps[g])
        );
    end

    bank_idx_t w_mid_bank;
    bank_idx_t w_bot_bank;

    assign w_mid_bank = r_rd_bank + 2'd1;
    assign w_bot_bank = r_rd_bank + 2'd2;

    assign o_pixel_data       = {w_taps[r_rd_bank], w_taps[w_mid_bank], w_taps[w_bot_bank]};
    assign o_pixel_data_valid = r_rd_active;
    assign o_intr             = r_intr;

endmodule : image_window_ctrl
`default_nettype wire

// File: doc/image_window_ctrl.md
# image_window_ctrl

Feeds the 3x3 convolution stage for blurring. Accepts a raster stream of 8-bit pixels from the DMA/AXI-stream input side and stores it across four rotating line banks. Once three full lines are buffered, it emits one 72-bit 3x3 window per cycle for a whole line. At the end of each line it raises a one-cycle interrupt so the host can send the next line.

## Interface
- LINE_WIDTH, 512: pixels per image line; power of two, ≥ 4.
- i_clk  in  1  clock; all logic is on the rising edge.
- i_rstn  in  1  synchronous, active-low reset.
- i_pixel_data  in  8  input pixel.
- i_pixel_data_valid  in  1  input pixel qualifier; there is no backpressure.
- o_pixel_data  out  72  3x3 window: {top[c],top[c+1],top[c+2], mid[c..c+2], bot[c..c+2]}, MSB first.
- o_pixel_data_valid  out  1  window qualifier; reset 0.
- o_intr  out  1  one-cycle pulse when a line read completes; reset 0.

## Operation
- Write side:
  - wr_col counts 0..LINE_WIDTH-1 on each valid pixel.
  - The pixel is written to bank wr_bank at address wr_col.
  - When wr_col wraps from LINE_WIDTH-1 to 0, wr_bank increments mod 4.
- Occupancy counter fill, width clog2(4*LINE_WIDTH)+1:
  - +1 on a write only.
  - -1 on a window output only.
  - Unchanged when both happen in the same cycle.
- Read FSM, two states:
  - IDLE: if fill ≥ 3*LINE_WIDTH, go to RD_LINE and set rd_active.
  - RD_LINE: rd_col increments every cycle. At rd_col == LINE_WIDTH-1:
    - rd_col returns to 0;
    - rd_bank increments mod 4;
    - rd_active clears;
    - o_intr pulses;
    - next state is IDLE.
- Row mapping: top = bank rd_bank, mid = bank rd_bank+1, bot = bank rd_bank+2 (all mod 4).
- Column taps use c = rd_col, c+1 and c+2 taken mod LINE_WIDTH. The last two windows of each line therefore wrap to columns 0 and 1; the downstream stage discards or pads them.
- o_pixel_data_valid = rd_active. o_pixel_data is a don't-care while valid is 0; bank contents are not reset.
- Flow control is the host's responsibility:
  - No more than one new line per o_intr after the initial 4 lines.
  - A write when fill == 4*LINE_WIDTH overwrites unread data. This is undefined use and is not detected.
- A write never targets a bank under read while the host obeys flow control; no collision logic.

## Timing
- Reset (i_rstn = 0 at an edge) clears wr_col, wr_bank, rd_col, rd_bank, fill, state=IDLE, rd_active, o_intr. Buffered pixels are abandoned.
- Reset mid-line: valid drops the cycle after the reset edge, no o_intr is issued, and the next image starts at bank 0.
- Read latency:
  - The write that makes fill reach 3*LINE_WIDTH is sampled at edge t.
  - The FSM sees the new fill and sets rd_active at edge t+1.
  - The first window is valid in the cycle after t+1.
- Bank reads are asynchronous (LUT RAM). A window reflects writes completed at prior edges.
- A burst is exactly LINE_WIDTH consecutive valid cycles with no gaps.
- o_intr is high for exactly one cycle, aligned with the first cycle after the last valid window.
- Minimum IDLE between bursts is 1 cycle. A new burst starts immediately after it if fill ≥ 3*LINE_WIDTH.
- Writes continue unaffected during bursts.

## Structure
- Package img_pkg holds:
  - PIXEL_W = 8, WINDOW_W = 72, NUM_BANKS = 4;
  - the FSM state enum {IDLE, RD_LINE};
  - a bank-index type of 2 bits.
- Sub-module line_bank, instantiated 4 times: LINE_WIDTH×8 storage with a write port (en, addr, data) and a 24-bit, 3-tap asynchronous read at addr, addr+1, addr+2 mod LINE_WIDTH.
- Row muxing by rd_bank, the counters and the FSM live in the top module.

## Test plan
Tests use LINE_WIDTH = 8 and pixel value = 16*line + col.
- Reset, then idle: o_pixel_data_valid = 0 and o_intr = 0 for 20 cycles.
- Write 3 lines back-to-back (24 pixels):
  - valid asserts 2 cycles after the last write and stays high exactly 8 cycles;
  - the first window is {00,01,02,10,11,12,20,21,22};
  - the window at c = 6 is {06,07,00,16,17,10,26,27,20};
  - o_intr pulses once, the cycle after valid drops.
- Write 4 lines, then one more line per o_intr for 6 lines total:
  - bursts use rows (0,1,2), (1,2,3), (2,3,0), (3,0,1);
  - the 4th burst's bot row holds line-5 data (5x values);
  - exactly 4 o_intr pulses.
- Write pixels every cycle during a burst: fill ends at the expected value (e.g. 25 written − 8 read = 17). No window is corrupted.
- Gapped input (valid every 3rd cycle): identical window content and intr count as back-to-back input.
- Assert i_rstn = 0 at the 4th cycle of a burst:
  - valid drops the next cycle with no o_intr;
  - after re-filling 3 lines, the first window is again from banks 0, 1, 2 with col 0.
